// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder that reuses one full-adder cell, LSB first (build with SERIAL_ADDER_SUB_EN to add subtract).
// Latency: start accepted at edge k, sum/cout/done update at edge k+WIDTH, busy drops at k+WIDTH+1.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
`timescale 1ns/1ps

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_sub;

    logic             w_load;
    logic             w_last;
    logic             w_b_bit;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_next;
    logic             w_unused_res_lsb;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_bit = r_b_sr[0] ^ r_sub;
`else
    assign w_b_bit = r_b_sr[0];
`endif

    // The shared full-adder cell
    assign w_s = r_a_sr[0] ^ w_b_bit ^ r_carry;
    assign w_c = (r_a_sr[0] & w_b_bit) | (r_a_sr[0] & r_carry) | (w_b_bit & r_carry);

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_s;
        end else begin : g_res_wn
            assign w_res_next = {w_s, r_res_sr[WIDTH-1:1]};
        end
    endgenerate

    // Bit 0 of the result shifter falls off the end once its slot is refilled.
    assign w_unused_res_lsb = r_res_sr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_sub    <= 1'b0;
        end else if (w_load) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_res_sr <= '0;
            r_cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub    <= sub;
            r_carry  <= sub ? 1'b1 : cin;
`else
            r_sub    <= 1'b0;
            r_carry  <= cin;
`endif
        end else if (r_state == S_RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= w_res_next;
            r_carry  <= w_c;
            r_cnt    <= r_cnt + 1'b1;
            // Publish only the completed word; sum/cout never show partials.
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_c;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 directed tests plus exhaustive WIDTH=2 and WIDTH=1 instances.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;

    logic       start8, cin8, sub8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    logic [8:0] exp8_q[$];
    logic [2:0] exp2_q[$];
    logic [1:0] exp1_q[$];

    int n_cmp;
    int n_err;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Scoreboards: every done pulse pops one expected {cout,sum}
    always @(negedge clk) begin
        if (done8) begin
            logic [8:0] e;
            n_cmp++;
            if (exp8_q.size() == 0) begin
                n_err++;
                $display("FAIL dut8_spurious_done got=%h expected no done", {cout8, sum8});
            end else begin
                e = exp8_q.pop_front();
                if ({cout8, sum8} !== e) begin
                    n_err++;
                    $display("FAIL dut8_result got=%h exp=%h", {cout8, sum8}, e);
                end
            end
        end
        if (done2) begin
            logic [2:0] e;
            n_cmp++;
            if (exp2_q.size() == 0) begin
                n_err++;
                $display("FAIL dut2_spurious_done got=%h", {cout2, sum2});
            end else begin
                e = exp2_q.pop_front();
                if ({cout2, sum2} !== e) begin
                    n_err++;
                    $display("FAIL dut2_result got=%h exp=%h", {cout2, sum2}, e);
                end
            end
        end
        if (done1) begin
            logic [1:0] e;
            n_cmp++;
            if (exp1_q.size() == 0) begin
                n_err++;
                $display("FAIL dut1_spurious_done got=%h", {cout1, sum1});
            end else begin
                e = exp1_q.pop_front();
                if ({cout1, sum1} !== e) begin
                    n_err++;
                    $display("FAIL dut1_result got=%h exp=%h", {cout1, sum1}, e);
                end
            end
        end
    end

    // Issue one WIDTH=8 op; lat = edges after the accept edge until done is seen.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic is, input logic [8:0] iexp,
                        output int lat, output logic busy_at_k);
        int guard;
        guard = 0;
        while (busy8 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy8) begin
            n_cmp++; n_err++;
            $display("FAIL run8_idle_timeout busy=%b", busy8);
        end
        a8 = ia; b8 = ib; cin8 = ic; sub8 = is; start8 = 1'b1;
        exp8_q.push_back(iexp);
        @(posedge clk); #1;
        start8 = 1'b0;
        busy_at_k = busy8;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy8, done8, cout8, sum8} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=000", {busy8, done8, cout8, sum8});
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy2, done2, busy1, done1} !== 4'h0) begin
            n_err++;
            $display("FAIL reset_small_outputs got=%b exp=0000", {busy2, done2, busy1, done1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat; logic bk;
        run8(8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096, lat, bk);
        n_cmp++;
        if (bk !== 1'b1) begin n_err++; $display("FAIL basic_busy_at_k got=%b exp=1", bk); end
        n_cmp++;
        if (lat !== 8) begin n_err++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        @(posedge clk); #1;
        n_cmp++;
        if ({done8, busy8} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_done_width got done,busy=%b exp=00", {done8, busy8});
        end
        n_cmp++;
        if ({cout8, sum8} !== 9'h096) begin
            n_err++;
            $display("FAIL basic_hold got=%h exp=096", {cout8, sum8});
        end
    endtask

    task automatic test_carry;
        int lat; logic bk;
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, lat, bk);
        n_cmp++;
        if (lat !== 8) begin n_err++; $display("FAIL carry1_latency got=%0d exp=8", lat); end
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, lat, bk);
        n_cmp++;
        if (lat !== 8) begin n_err++; $display("FAIL carry2_latency got=%0d exp=8", lat); end
    endtask

    task automatic test_busy_protect;
        int guard; int lat;
        guard = 0;
        while (busy8 && guard < 50) begin @(posedge clk); #1; guard++; end
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(9'h033);
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (done8 !== (i == 8)) begin
                n_err++;
                $display("FAIL protect_done_timing edge=k+%0d got=%b", i, done8);
            end
        end
        a8 = 8'h40; b8 = 8'h05; cin8 = 1'b0;
        exp8_q.push_back(9'h045);
        @(posedge clk); #1;
        n_cmp++;
        if ({busy8, done8} !== 2'b00) begin
            n_err++;
            $display("FAIL protect_release got busy,done=%b exp=00", {busy8, done8});
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        n_cmp++;
        if (busy8 !== 1'b1) begin n_err++; $display("FAIL protect_second_accept got=%b exp=1", busy8); end
        n_cmp++;
        if ({cout8, sum8} !== 9'h033) begin
            n_err++;
            $display("FAIL protect_hold_during_run got=%h exp=033", {cout8, sum8});
        end
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat !== 8) begin n_err++; $display("FAIL protect_second_latency got=%0d exp=8", lat); end
    endtask

    task automatic test_reset_mid;
        int guard; int seen; int lat; logic bk;
        guard = 0;
        while (busy8 && guard < 50) begin @(posedge clk); #1; guard++; end
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(9'h100);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy8, done8, cout8, sum8} !== 11'h000) begin
            n_err++;
            $display("FAIL midreset_outputs got=%h exp=000", {busy8, done8, cout8, sum8});
        end
        exp8_q.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
        run8(8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096, lat, bk);
        n_cmp++;
        if (lat !== 8) begin n_err++; $display("FAIL midreset_restart_latency got=%0d exp=8", lat); end
    endtask

    task automatic test_exhaustive_w2;
        int guard; int lat;
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    guard = 0;
                    while (busy2 && guard < 20) begin @(posedge clk); #1; guard++; end
                    a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
                    exp2_q.push_back(3'(ia + ib + ic));
                    @(posedge clk); #1;
                    start2 = 1'b0;
                    lat = 0;
                    while (!done2 && lat < 10) begin @(posedge clk); #1; lat++; end
                    n_cmp++;
                    if (lat !== 2) begin
                        n_err++;
                        $display("FAIL w2_latency a=%0d b=%0d cin=%0d got=%0d exp=2", ia, ib, ic, lat);
                    end
                end
            end
        end
    endtask

    task automatic test_width1;
        int guard; int lat;
        for (int v = 0; v < 8; v++) begin
            guard = 0;
            while (busy1 && guard < 20) begin @(posedge clk); #1; guard++; end
            a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v);
            start1 = 1'b1;
            exp1_q.push_back(2'(((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1)));
            @(posedge clk); #1;
            start1 = 1'b0;
            lat = 0;
            while (!done1 && lat < 10) begin @(posedge clk); #1; lat++; end
            n_cmp++;
            if (lat !== 1) begin n_err++; $display("FAIL w1_latency v=%0d got=%0d exp=1", v, lat); end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat; logic bk;
        run8(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, lat, bk);
        n_cmp++;
        if (lat !== 8) begin n_err++; $display("FAIL sub1_latency got=%0d exp=8", lat); end
        run8(8'h01, 8'h02, 1'b1, 1'b1, 9'h0FF, lat, bk);
        n_cmp++;
        if (lat !== 8) begin n_err++; $display("FAIL sub2_latency got=%0d exp=8", lat); end
        run8(8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096, lat, bk);
        n_cmp++;
        if (lat !== 8) begin n_err++; $display("FAIL sub0_latency got=%0d exp=8", lat); end
    endtask
`endif

    task automatic test_drain;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (exp8_q.size() !== 0) begin n_err++; $display("FAIL dut8_missed_done left=%0d exp=0", exp8_q.size()); end
        n_cmp++;
        if (exp2_q.size() !== 0) begin n_err++; $display("FAIL dut2_missed_done left=%0d exp=0", exp2_q.size()); end
        n_cmp++;
        if (exp1_q.size() !== 0) begin n_err++; $display("FAIL dut1_missed_done left=%0d exp=0", exp1_q.size()); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_busy_protect();
        test_reset_mid();
        test_exhaustive_w2();
        test_width1();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
